// File: rtl/adder_bist_diag.sv
// WIDTH-stage ripple-carry adder with one injectable faulty stage, a per-stage
// BIST sequencer and first-failure diagnosis; a registered adder when idle.
//
// state | meaning
// IDLE  | functional adder, op_sum tracks operands, waits for start
// RUN   | one directed vector compared per cycle, fault config frozen
module adder_bist_diag #(
  parameter int WIDTH        = 8,
  parameter bit STOP_ON_FAIL = 1'b0,
  localparam int VW = $clog2(8*WIDTH),
  localparam int SW = $clog2(WIDTH),
  localparam int CW = VW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             fault_en,
  input  logic [SW-1:0]    fault_stage,
  input  logic [1:0]       fault_type,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [WIDTH:0]   op_sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    fail_count,
  output logic [VW-1:0]    first_fail_idx,
  output logic [SW-1:0]    first_fail_stage,
  output logic [WIDTH:0]   first_fail_syndrome
);

  localparam int            NVEC     = 8*WIDTH;
  localparam logic [VW-1:0] LAST_IDX = VW'(NVEC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(NVEC);
  localparam logic [SW:0]   STAGES   = (SW+1)'(WIDTH);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [VW-1:0]    vidx_q, vidx_d;
  logic             flt_en_q, flt_en_d;
  logic [SW-1:0]    flt_stage_q, flt_stage_d;
  logic [1:0]       flt_type_q, flt_type_d;
  logic [WIDTH:0]   op_sum_q, op_sum_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CW-1:0]    fcnt_q, fcnt_d;
  logic [VW-1:0]    ff_idx_q, ff_idx_d;
  logic [SW-1:0]    ff_stage_q, ff_stage_d;
  logic [WIDTH:0]   ff_syn_q, ff_syn_d;

  logic [SW-1:0]    vec_stage;
  logic             va, vb, vc;
  logic [WIDTH-1:0] vec_a, vec_b;
  logic             vec_cin;
  logic [WIDTH:0]   golden;

  logic [WIDTH-1:0] ch_a, ch_b;
  logic             ch_cin;
  logic             f_en, f_hit;
  logic [SW-1:0]    f_stage;
  logic [1:0]       f_type;
  logic [WIDTH:0]   ch_sum;
  logic             carry, s, co;

  logic             mismatch;
  logic             last_cmp;

  // Stage under test sees a,b at bit i; c is fed as a generate pair at bit i-1.
  always_comb begin
    vec_stage    = vidx_q[VW-1:3];
    {va, vb, vc} = vidx_q[2:0];
    vec_a        = '0;
    vec_b        = '0;
    vec_cin      = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (j == int'(vec_stage)) begin
        vec_a[j] = va;
        vec_b[j] = vb;
      end else if (j + 1 == int'(vec_stage)) begin
        vec_a[j] = vc;
        vec_b[j] = vc;
      end
    end
    if (vec_stage == '0) vec_cin = vc;
    golden = {1'b0, vec_a} + {1'b0, vec_b} + {{WIDTH{1'b0}}, vec_cin};
  end

  always_comb begin
    if (state_q == S_RUN) begin
      ch_a    = vec_a;
      ch_b    = vec_b;
      ch_cin  = vec_cin;
      f_en    = flt_en_q;
      f_stage = flt_stage_q;
      f_type  = flt_type_q;
    end else begin
      ch_a    = op_a;
      ch_b    = op_b;
      ch_cin  = op_cin;
      f_en    = fault_en;
      f_stage = fault_stage;
      f_type  = fault_type;
    end
    f_hit = f_en && ({1'b0, f_stage} < STAGES);
  end

  always_comb begin
    carry  = ch_cin;
    ch_sum = '0;
    s      = 1'b0;
    co     = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      s  = ch_a[j] ^ ch_b[j] ^ carry;
      co = (ch_a[j] & ch_b[j]) | (carry & (ch_a[j] ^ ch_b[j]));
      if (f_hit && (j == int'(f_stage))) begin
        case (f_type)
          2'b00:   s  = ch_a[j] ^ ch_b[j];
          2'b01:   co = ch_a[j] & ch_b[j];
          2'b10:   co = 1'b0;
          default: s  = ~s;
        endcase
      end
      ch_sum[j] = s;
      carry     = co;
    end
    ch_sum[WIDTH] = carry;
  end

  assign mismatch = (state_q == S_RUN) && (ch_sum != golden);
  assign last_cmp = (vidx_q == LAST_IDX) || (STOP_ON_FAIL && mismatch);

  always_comb begin
    state_d     = state_q;
    vidx_d      = vidx_q;
    flt_en_d    = flt_en_q;
    flt_stage_d = flt_stage_q;
    flt_type_d  = flt_type_q;
    op_sum_d    = op_sum_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fcnt_d      = fcnt_q;
    ff_idx_d    = ff_idx_q;
    ff_stage_d  = ff_stage_q;
    ff_syn_d    = ff_syn_q;
    case (state_q)
      S_IDLE: begin
        op_sum_d = ch_sum;
        if (start) begin
          state_d     = S_RUN;
          vidx_d      = '0;
          flt_en_d    = fault_en;
          flt_stage_d = fault_stage;
          flt_type_d  = fault_type;
          fcnt_d      = '0;
          ff_idx_d    = '0;
          ff_stage_d  = '0;
          ff_syn_d    = '0;
        end
      end
      S_RUN: begin
        vidx_d = vidx_q + VW'(1);
        if (mismatch) begin
          if (fcnt_q != CNT_MAX) fcnt_d = fcnt_q + CW'(1);
          if (fcnt_q == '0) begin
            ff_idx_d   = vidx_q;
            ff_stage_d = vec_stage;
            ff_syn_d   = golden ^ ch_sum;
          end
        end
        if (last_cmp) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          pass_d  = (fcnt_q == '0) && !mismatch;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vidx_q      <= '0;
      flt_en_q    <= 1'b0;
      flt_stage_q <= '0;
      flt_type_q  <= '0;
      op_sum_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fcnt_q      <= '0;
      ff_idx_q    <= '0;
      ff_stage_q  <= '0;
      ff_syn_q    <= '0;
    end else begin
      state_q     <= state_d;
      vidx_q      <= vidx_d;
      flt_en_q    <= flt_en_d;
      flt_stage_q <= flt_stage_d;
      flt_type_q  <= flt_type_d;
      op_sum_q    <= op_sum_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fcnt_q      <= fcnt_d;
      ff_idx_q    <= ff_idx_d;
      ff_stage_q  <= ff_stage_d;
      ff_syn_q    <= ff_syn_d;
    end
  end

  assign op_sum              = op_sum_q;
  assign busy                = (state_q == S_RUN);
  assign done                = done_q;
  assign pass                = pass_q;
  assign fail_count          = fcnt_q;
  assign first_fail_idx      = ff_idx_q;
  assign first_fail_stage    = ff_stage_q;
  assign first_fail_syndrome = ff_syn_q;

endmodule
